// File: rtl/ras_sequencer.sv
// Return-address-stack sequencer: turns front-end call/ret/branch requests and execute
// resolutions into registered RAS pulses. Optional event counters under RAS_SEQ_STATS_EN.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_RUN     | normal operation, requests accepted subject to checkpoint limit
//  S_RECOVER | post-flush bubble, fe_ready low while recovery counter runs
module ras_sequencer #(
  parameter int WIDTH          = 32,
  parameter int MAXBRANCHES    = 16,
  parameter int BRANCHES_ADDR  = 4,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fe_valid,
  output logic                     fe_ready,
  input  logic                     fe_call,
  input  logic                     fe_ret,
  input  logic                     fe_br,
  input  logic [WIDTH-1:0]         fe_addr,
  input  logic                     rs_valid,
  input  logic                     rs_mispredict,
  input  logic                     ras_empty,
  output logic                     ras_push,
  output logic                     ras_pop,
  output logic                     ras_branch,
  output logic                     ras_close_valid,
  output logic                     ras_close_invalid,
  output logic [WIDTH-1:0]         ras_din,
  output logic [BRANCHES_ADDR:0]   outstanding,
  output logic                     err_underflow,
  output logic [15:0]              stat_push,
  output logic [15:0]              stat_pop,
  output logic [15:0]              stat_flush,
  output logic [15:0]              stat_stall
);

  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RCW-1:0] REC_LOAD = RCW'(RECOVER_CYCLES - 1);
  localparam logic [BRANCHES_ADDR:0] MAXB = (BRANCHES_ADDR + 1)'(MAXBRANCHES);

  typedef enum logic {S_RUN, S_RECOVER} state_t;

  state_t                 r_state, w_state_nxt;
  logic [RCW-1:0]         r_rec_cnt, w_rec_cnt_nxt;
  logic [BRANCHES_ADDR:0] r_outstanding, w_outstanding_nxt;
  logic                   r_push, r_pop, r_branch, r_close_v, r_close_i, r_err;
  logic [WIDTH-1:0]       r_din;

  logic w_mis, w_cor, w_full, w_ready, w_accept, w_br_acc;
  logic w_close_v, w_close_i, w_uf_set;

  assign w_mis    = rs_valid & rs_mispredict;
  assign w_cor    = rs_valid & ~rs_mispredict;
  assign w_full   = (r_outstanding == MAXB);
  // fe_ready is forced low while in reset so nothing is accepted before the first edge
  assign w_ready  = rst_n && (r_state == S_RUN) && !w_mis && !(fe_br && w_full && !w_cor);
  assign w_accept = fe_valid & w_ready;
  assign w_br_acc = w_accept & fe_br;

  always_comb begin
    w_state_nxt       = r_state;
    w_rec_cnt_nxt     = r_rec_cnt;
    w_outstanding_nxt = r_outstanding;
    w_close_v         = 1'b0;
    w_close_i         = 1'b0;
    w_uf_set          = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mis) begin
          if (r_outstanding != '0) begin
            w_close_i         = 1'b1;
            w_outstanding_nxt = '0;
            w_state_nxt       = S_RECOVER;
            w_rec_cnt_nxt     = REC_LOAD;
          end else begin
            w_uf_set = 1'b1;
          end
        end else begin
          if (w_cor) begin
            if (r_outstanding != '0) w_close_v = 1'b1;
            else                     w_uf_set  = 1'b1;
          end
          case ({w_br_acc, w_close_v})
            2'b10:   w_outstanding_nxt = r_outstanding + 1'b1;
            2'b01:   w_outstanding_nxt = r_outstanding - 1'b1;
            default: w_outstanding_nxt = r_outstanding;
          endcase
        end
      end
      S_RECOVER: begin
        // correct resolutions here belong to flushed branches and are dropped
        if (w_mis)                  w_rec_cnt_nxt = REC_LOAD;
        else if (r_rec_cnt == '0)   w_state_nxt   = S_RUN;
        else                        w_rec_cnt_nxt = r_rec_cnt - 1'b1;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_rec_cnt     <= '0;
      r_outstanding <= '0;
      r_push        <= 1'b0;
      r_pop         <= 1'b0;
      r_branch      <= 1'b0;
      r_close_v     <= 1'b0;
      r_close_i     <= 1'b0;
      r_err         <= 1'b0;
      r_din         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rec_cnt     <= w_rec_cnt_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_push        <= w_accept & fe_call;
      r_pop         <= w_accept & fe_ret;
      r_branch      <= w_br_acc;
      r_close_v     <= w_close_v;
      r_close_i     <= w_close_i;
      if (w_uf_set) r_err <= 1'b1;
      if (w_accept && fe_call) r_din <= fe_addr;
    end
  end

  assign fe_ready          = w_ready;
  assign ras_push          = r_push;
  assign ras_pop           = r_pop;
  assign ras_branch        = r_branch;
  assign ras_close_valid   = r_close_v;
  assign ras_close_invalid = r_close_i;
  assign ras_din           = r_din;
  assign outstanding       = r_outstanding;
  assign err_underflow     = r_err;

`ifdef RAS_SEQ_STATS_EN
  logic [15:0] r_stat_push, r_stat_pop, r_stat_flush, r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_push  <= '0;
      r_stat_pop   <= '0;
      r_stat_flush <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_push && r_stat_push != 16'hFFFF)                r_stat_push  <= r_stat_push + 1'b1;
      if (r_pop && !ras_empty && r_stat_pop != 16'hFFFF)    r_stat_pop   <= r_stat_pop + 1'b1;
      if (r_close_i && r_stat_flush != 16'hFFFF)            r_stat_flush <= r_stat_flush + 1'b1;
      if (fe_valid && !w_ready && r_stat_stall != 16'hFFFF) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_push  = r_stat_push;
  assign stat_pop   = r_stat_pop;
  assign stat_flush = r_stat_flush;
  assign stat_stall = r_stat_stall;
`else
  // ras_empty only feeds the pop statistic
  logic w_unused;
  assign w_unused   = ras_empty;
  assign stat_push  = '0;
  assign stat_pop   = '0;
  assign stat_flush = '0;
  assign stat_stall = '0;
`endif

endmodule
